// File: rtl/vector_check_sequencer.sv
// Table-driven stimulus/check engine: applies stored vectors to a block under test,
// waits a settle time, compares masked responses and reports error count and first failure.
module vector_check_sequencer #(
  parameter  int IN_W    = 2,
  parameter  int OUT_W   = 2,
  parameter  int NUM_VEC = 5,
  parameter  int SETTLE  = 1,
  parameter  int ERR_W   = 8,
  localparam int ADDR_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic              fast_clock,
  input  logic              reset_n,
  input  logic              start_process,
  input  logic              stop_on_fail,
  input  logic              vec_wr_en,
  input  logic [ADDR_W-1:0] vec_wr_addr,
  input  logic [IN_W-1:0]   vec_wr_stim,
  input  logic [OUT_W-1:0]  vec_wr_exp,
  input  logic [OUT_W-1:0]  vec_wr_mask,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              first_fail_vld
);

  // state | meaning
  // IDLE  | no run since reset, waiting for start_process
  // WAIT  | vector applied, settle counter running down
  // CHECK | masked compare of dut_out against expected
  // DONE  | run finished, results held until next start
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stop_q, stop_d;
  logic [IN_W-1:0]     dut_in_q, dut_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   ffi_q, ffi_d;
  logic                ffv_q, ffv_d;

  logic [IN_W-1:0]     stim_q [NUM_VEC];
  logic [IN_W-1:0]     stim_d [NUM_VEC];
  logic [OUT_W-1:0]    exp_q  [NUM_VEC];
  logic [OUT_W-1:0]    exp_d  [NUM_VEC];
  logic [OUT_W-1:0]    mask_q [NUM_VEC];
  logic [OUT_W-1:0]    mask_d [NUM_VEC];

  logic                idle_or_done;
  logic                mism;
  logic                last_vec;
  logic [ADDR_W-1:0]   idx_nxt;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign idx_nxt      = idx_q + ADDR_W'(1);
  assign mism         = |((dut_out ^ exp_q[idx_q]) & mask_q[idx_q]);
  assign last_vec     = (idx_q == ADDR_W'(NUM_VEC - 1)) || (stop_q && mism);

  always_comb begin
    stim_d = stim_q;
    exp_d  = exp_q;
    mask_d = mask_q;
    if (vec_wr_en && idle_or_done && (32'(vec_wr_addr) < NUM_VEC)) begin
      stim_d[vec_wr_addr] = vec_wr_stim;
      exp_d[vec_wr_addr]  = vec_wr_exp;
      mask_d[vec_wr_addr] = vec_wr_mask;
    end
  end

  // Table is deliberately not reset so a reset between runs keeps the loaded vectors.
  always_ff @(posedge fast_clock) begin
    if (reset_n) begin
      stim_q <= stim_d;
      exp_q  <= exp_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    dut_in_d = dut_in_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ffi_d    = ffi_q;
    ffv_d    = ffv_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_process) begin
          idx_d    = '0;
          dut_in_d = stim_q[0];
          cnt_d    = CNT_W'(SETTLE);
          stop_d   = stop_on_fail;
          err_d    = '0;
          ffi_d    = '0;
          ffv_d    = 1'b0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CHECK: begin
        if (mism) begin
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
          if (!ffv_q) begin
            ffi_d = idx_q;
            ffv_d = 1'b1;
          end
        end
        if (last_vec) begin
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d    = idx_nxt;
          dut_in_d = stim_q[idx_nxt];
          cnt_d    = CNT_W'(SETTLE);
          state_d  = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fast_clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ffi_q    <= '0;
      ffv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ffi_q    <= ffi_d;
      ffv_q    <= ffv_d;
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_vector_check_sequencer.sv
// Bench for vector_check_sequencer driving a half adder; instance a has 5 vectors and an
// 8-bit error counter, instance b has 4 vectors and a 2-bit counter to reach saturation.
module tb_vector_check_sequencer;
  localparam int SETTLE = 1;

  logic fast_clock = 1'b0;
  always #5 fast_clock = ~fast_clock;

  logic       reset_n;
  logic [1:0] start, stop, wr_en;
  logic [2:0] wr_addr;
  logic [1:0] wr_stim, wr_exp, wr_mask;

  logic [1:0] dut_in_a, dut_out_a, dut_in_b, dut_out_b;
  logic       busy_a, done_a, pass_a, ffv_a;
  logic       busy_b, done_b, pass_b, ffv_b;
  logic [7:0] err_a;
  logic [1:0] err_b;
  logic [2:0] ffi_a;
  logic [1:0] ffi_b;

  function automatic logic [1:0] ha(input logic [1:0] x);
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  assign dut_out_a = ha(dut_in_a);
  assign dut_out_b = ha(dut_in_b);

  vector_check_sequencer #(.IN_W(2), .OUT_W(2), .NUM_VEC(5), .SETTLE(SETTLE), .ERR_W(8)) u_a (
    .fast_clock(fast_clock), .reset_n(reset_n), .start_process(start[0]), .stop_on_fail(stop[0]),
    .vec_wr_en(wr_en[0]), .vec_wr_addr(wr_addr), .vec_wr_stim(wr_stim), .vec_wr_exp(wr_exp),
    .vec_wr_mask(wr_mask), .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_fail_idx(ffi_a), .first_fail_vld(ffv_a));

  vector_check_sequencer #(.IN_W(2), .OUT_W(2), .NUM_VEC(4), .SETTLE(SETTLE), .ERR_W(2)) u_b (
    .fast_clock(fast_clock), .reset_n(reset_n), .start_process(start[1]), .stop_on_fail(stop[1]),
    .vec_wr_en(wr_en[1]), .vec_wr_addr(wr_addr[1:0]), .vec_wr_stim(wr_stim), .vec_wr_exp(wr_exp),
    .vec_wr_mask(wr_mask), .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_fail_idx(ffi_b), .first_fail_vld(ffv_b));

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] m_stim [2][5];
  logic [1:0] m_exp  [2][5];
  logic [1:0] m_mask [2][5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check_eq({tag, " dut_in"}, sel ? dut_in_b : dut_in_a, 0);
    check_eq({tag, " busy"},   sel ? busy_b   : busy_a,   0);
    check_eq({tag, " done"},   sel ? done_b   : done_a,   0);
    check_eq({tag, " pass"},   sel ? pass_b   : pass_a,   0);
    check_eq({tag, " err"},    sel ? err_b    : err_a,    0);
    check_eq({tag, " ffi"},    sel ? ffi_b    : ffi_a,    0);
    check_eq({tag, " ffv"},    sel ? ffv_b    : ffv_a,    0);
  endtask

  task automatic vec_write(input int sel, input int addr, input logic [1:0] s,
                           input logic [1:0] e, input logic [1:0] m);
    @(negedge fast_clock);
    wr_en[sel] = 1'b1;
    wr_addr    = 3'(addr);
    wr_stim    = s;
    wr_exp     = e;
    wr_mask    = m;
    @(negedge fast_clock);
    wr_en[sel] = 1'b0;
    if (addr < (sel ? 4 : 5)) begin
      m_stim[sel][addr] = s;
      m_exp[sel][addr]  = e;
      m_mask[sel][addr] = m;
    end
  endtask

  // Reference: walk the table, count masked mismatches, stop early if requested.
  task automatic run_check(input int sel, input bit stp, input bit disturb, input string tag);
    int n, errmax, err, ffi, last, exp_edges, edges;
    bit ffv, seen, mism;
    n = sel ? 4 : 5;
    errmax = sel ? 3 : 255;
    err = 0; ffi = 0; ffv = 0; last = n - 1;
    for (int i = 0; i < n; i++) begin
      mism = |((ha(m_stim[sel][i]) ^ m_exp[sel][i]) & m_mask[sel][i]);
      if (mism) begin
        if (err < errmax) err++;
        if (!ffv) begin ffv = 1; ffi = i; end
        if (stp) begin last = i; break; end
      end
    end
    exp_edges = (last + 1) * (SETTLE + 2);

    @(negedge fast_clock);
    start[sel] = 1'b1;
    stop[sel]  = stp;
    @(negedge fast_clock);
    start[sel] = 1'b0;
    stop[sel]  = 1'b0;
    check_eq({tag, " busy_run"}, sel ? busy_b : busy_a, 1);
    edges = 0;
    seen  = 0;
    while (!seen && edges < 300) begin
      @(posedge fast_clock);
      edges++;
      #1;
      seen = sel ? done_b : done_a;
      if (disturb && edges == 2) begin
        start[sel] = 1'b1;
        stop[sel]  = 1'b1;
        wr_en[sel] = 1'b1;
        wr_addr    = 3'd0;
        wr_stim    = ~m_stim[sel][0];
        wr_exp     = ~m_exp[sel][0];
        wr_mask    = 2'b11;
      end
      if (disturb && edges == 3) begin
        start[sel] = 1'b0;
        stop[sel]  = 1'b0;
        wr_en[sel] = 1'b0;
      end
    end
    check_eq({tag, " done_edge"}, edges, exp_edges);
    check_eq({tag, " err"},    sel ? err_b : err_a, err);
    check_eq({tag, " ffi"},    sel ? ffi_b : ffi_a, ffi);
    check_eq({tag, " ffv"},    sel ? ffv_b : ffv_a, ffv);
    check_eq({tag, " pass"},   sel ? pass_b : pass_a, (err == 0));
    check_eq({tag, " dut_in"}, sel ? dut_in_b : dut_in_a, m_stim[sel][last]);
    check_eq({tag, " busy_end"}, sel ? busy_b : busy_a, 0);
    repeat (2) @(posedge fast_clock);
    #1;
    check_eq({tag, " done_hold"}, sel ? done_b : done_a, 1);
  endtask

  initial begin
    logic [1:0] s, e;
    reset_n = 1'b0;
    start = '0; stop = '0; wr_en = '0;
    wr_addr = '0; wr_stim = '0; wr_exp = '0; wr_mask = '0;

    repeat (3) @(posedge fast_clock);
    #1;
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    @(negedge fast_clock);
    reset_n = 1'b1;
    repeat (3) @(posedge fast_clock);
    #1;
    check_idle(0, "idle_a");
    check_idle(1, "idle_b");

    for (int i = 0; i < 4; i++) begin
      vec_write(1, i, 2'(i), ha(2'(i)), 2'b11);
      vec_write(0, i, 2'(i), ha(2'(i)), 2'b11);
    end
    run_check(1, 0, 0, "ha4");

    vec_write(0, 4, 2'b01, 2'b11, 2'b11);
    vec_write(0, 5, 2'b11, 2'b00, 2'b11);
    vec_write(0, 7, 2'b11, 2'b00, 2'b11);
    run_check(0, 0, 0, "vec4_bad");

    vec_write(0, 1, 2'b01, 2'b11, 2'b11);
    run_check(0, 1, 0, "stop_fail");

    vec_write(0, 1, 2'b01, 2'b01, 2'b11);
    vec_write(0, 4, 2'b01, 2'b11, 2'b01);
    run_check(0, 0, 0, "mask01");

    for (int i = 0; i < 4; i++) vec_write(1, i, 2'(i), ~ha(2'(i)), 2'b11);
    run_check(1, 0, 0, "sat");

    run_check(0, 0, 1, "disturb");

    @(negedge fast_clock);
    start[0] = 1'b1;
    @(negedge fast_clock);
    start[0] = 1'b0;
    repeat (7) @(posedge fast_clock);
    #1;
    reset_n = 1'b0;
    @(posedge fast_clock);
    #1;
    check_idle(0, "midrst_a");
    check_idle(1, "midrst_b");
    @(negedge fast_clock);
    reset_n = 1'b1;
    run_check(0, 0, 0, "rerun");

    for (int it = 0; it < 24; it++) begin
      int sel;
      sel = it % 2;
      for (int i = 0; i < (sel ? 4 : 5); i++) begin
        s = 2'($urandom);
        e = ha(s);
        if ($urandom_range(0, 2) == 0) e = e ^ 2'($urandom_range(1, 3));
        vec_write(sel, i, s, e, 2'($urandom));
      end
      run_check(sel, 1'($urandom), (sel == 0) && (it % 4 == 0), $sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
